fixed2float_seq: RTL

- Sequential, parametrised successor to the combinational integer/fraction-to-IEEE754 converter in the ALU path.
- Accepts a fixed-point value split into an integer field and a fraction field. Supports unsigned or two's-complement input.
- Produces an IEEE754 single-precision word with round-to-nearest-even, plus inexact and overflow flags.
- Uses a valid/ready handshake on both sides. Normalisation is iterative, one bit per cycle.

---
 rtl/fixed2float_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fixed2float_seq.sv
// Sequential fixed-point to IEEE754 single-precision converter.
// Normalises one bit per cycle, then rounds to nearest-even; valid/ready on both sides.
module fixed2float_seq #(
  parameter int INT_W  = 32,
  parameter int FRAC_W = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [INT_W-1:0]                          integer_part,
  input  logic [(FRAC_W > 0 ? FRAC_W : 1)-1:0]      fractional_part,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [31:0]                               ieee754_output,
  output logic                                      inexact,
  output logic                                      overflow
);

  localparam int W = INT_W + FRAC_W;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [W-1:0]       r_m;
  logic signed [9:0]  r_e;
  logic               r_sign;
  logic [31:0]        r_out;
  logic               r_inexact;
  logic               r_overflow;

  logic [W-1:0]       w_in;
  logic [W-1:0]       w_mag;
  logic               w_neg;
  logic               w_zero;
  logic [22:0]        w_mant;
  logic               w_guard;
  logic [W-1:0]       w_low;
  logic               w_sticky;
  logic               w_up;
  logic [23:0]        w_sum;
  logic signed [9:0]  w_e_rnd;
  logic               w_ovf;

  // A zero-width fraction still has a 1-bit port; it carries no value.
  generate
    if (FRAC_W == 0) begin : g_no_frac
      logic w_unused_frac;
      assign w_unused_frac = ^fractional_part;
      assign w_in          = integer_part;
    end else begin : g_frac
      assign w_in = {integer_part, fractional_part};
    end
  endgenerate

  assign w_neg  = SIGNED && w_in[W-1];
  assign w_mag  = w_neg ? (~w_in) + W'(1) : w_in;
  assign w_zero = (w_mag == '0);

  // Shifting out the top 25 bits leaves exactly the sticky field, empty when W == 25.
  assign w_mant   = r_m[W-2 -: 23];
  assign w_guard  = r_m[W-25];
  assign w_low    = r_m << 25;
  assign w_sticky = |w_low;
  assign w_up     = w_guard & (w_sticky | w_mant[0]);
  assign w_sum    = {1'b0, w_mant} + 24'(w_up);
  assign w_e_rnd  = r_e + $signed({9'd0, w_sum[23]});
  assign w_ovf    = (w_e_rnd >= 10'sd255);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_zero ? DONE : NORM;
      end
      NORM:  if (r_m[W-1]) w_next = ROUND;
      ROUND: w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m        <= '0;
      r_e        <= '0;
      r_sign     <= 1'b0;
      r_out      <= '0;
      r_inexact  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_m    <= w_mag;
            r_e    <= 10'(INT_W + 126);
            r_sign <= w_neg;
            if (w_zero) begin
              r_out      <= '0;
              r_inexact  <= 1'b0;
              r_overflow <= 1'b0;
            end
          end
        end
        NORM: begin
          if (!r_m[W-1]) begin
            r_m <= r_m << 1;
            r_e <= r_e - 10'sd1;
          end
        end
        ROUND: begin
          r_inexact  <= w_guard | w_sticky;
          r_overflow <= w_ovf;
          r_out      <= w_ovf ? {r_sign, 8'hFF, 23'h0} : {r_sign, w_e_rnd[7:0], w_sum[22:0]};
        end
        default: ;
      endcase
    end
  end

  assign ieee754_output = r_out;
  assign inexact        = r_inexact;
  assign overflow       = r_overflow;

endmodule
